branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Registered, parametrised branch/jump resolution stage for the decode-stage early-branch path. It accepts one control-flow op per handshake, evaluates all six RV32I/RV64I conditional compares (including correct `>=` semantics for bge/bgeu), JAL and JALR, and computes the target. It checks the result against the fetch-stage prediction and presents a registered outcome with a redirect PC to fetch/hazard logic. It also keeps saturating statistics counters.

## Interface
- XLEN, 32: operand/PC width (32 or 64)
- CNT_W, 16: width of each statistics counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  request valid
- in_ready  out  1  stage can accept
- rs1, rs2  in  XLEN  register operands
- pc, imm  in  XLEN  instruction PC; sign-extended immediate
- funct3  in  3  branch condition
- is_branch, is_jal, is_jalr  in  1 each  op class
- pred_taken  in  1  fetch prediction
- pred_target  in  XLEN  predicted target
- flush  in  1  kill in-flight and incoming op
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_taken, out_mispredict, out_illegal  out  1 each  registered outcome
- out_target, out_redirect_pc  out  XLEN  computed target; correct next PC
- stat_clr  in  1  synchronous counter clear
- cnt_branch, cnt_taken, cnt_mispred  out  CNT_W each  statistics

## Operation
- Op class priority: is_jalr > is_jal > is_branch > none (non-control).
- Branch compares: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. Funct3 010/011 with is_branch: taken=0, illegal=1.
- Targets use modulo 2^XLEN arithmetic with wrap and no overflow flag.
  - Branch/JAL: pc+imm.
  - JALR: (rs1+imm) with bit 0 cleared.
  - Non-control: target=pc+4.
- JAL/JALR are always taken.
- taken_next: the resolved outcome, redirect = taken ? target : pc+4 (wraps).
- mispredict = (taken != pred_taken) || (taken && pred_target != target).
- Non-control op: mispredict = pred_taken.
- Capture happens on in_valid && in_ready && !flush. On capture, all out_* fields register and out_valid becomes 1.
- Counters update on capture only, and saturate at 2^CNT_W−1.
  - cnt_branch: +1 for is_branch ops, including illegal ones.
  - cnt_taken: +1 for taken conditional branches.
  - cnt_mispred: +1 for any mispredict.
- stat_clr zeroes all counters. If stat_clr coincides with a capture, the clear wins and counters read 0.

## Timing
- Reset values: out_valid=0, out_taken=0, out_mispredict=0, out_illegal=0, out_target=0, out_redirect_pc=0, all counters 0. in_ready reads 1 once out_valid=0.
- Latency is 1 cycle from capture edge to out_valid.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput of one op/cycle under continuous out_ready.
- Output holds stable while out_valid && !out_ready.
- A transfer completes on out_valid && out_ready. If there is no new capture in the same cycle, out_valid clears next cycle.
- flush: out_valid=0 on the next edge. The op presented that cycle is dropped and no counters update. flush overrides out_ready and capture.
- rst_n asserted mid-operation clears state immediately (async), and the held result is lost. On deassertion the stage resumes idle on the next edge.

## Test plan
- Branch type sweep:
  - Stimulus: rs1=0xFFFFFFFF, rs2=0x00000001, pc=0x100, imm=0x20, pred_taken=0; each funct3 in turn.
  - Response: beq 0, bne 1, blt 1, bge 0, bltu 0, bgeu 1. Taken cases give target 0x120, redirect 0x120, mispredict=1.
- Equality corner:
  - Stimulus: bge and bgeu with rs1=rs2=5.
  - Response: taken=1 for both.
  - Stimulus: funct3=010.
  - Response: illegal=1, taken=0, redirect=pc+4, cnt_branch incremented.
- JALR and wrap:
  - Stimulus: rs1=0xFFFFFFF0, imm=0x13, pred_taken=1, pred_target=0x2.
  - Response: target 0x2 (bit0 cleared, wrapped), mispredict=0.
  - Stimulus: pc=0xFFFFFFFC, non-taken branch.
  - Response: redirect=0x0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid held.
  - Response: in_ready=0 after the first capture, output fields stable.
  - Stimulus: out_ready=1.
  - Response: the next op captures in the same cycle, with no loss or duplication.
- Flush and reset:
  - Stimulus: flush with out_valid=1 and in_valid=1.
  - Response: out_valid=0 next cycle, counters unchanged.
  - Stimulus: rst_n low mid-stall.
  - Response: all outputs 0 immediately.
- Counters (CNT_W=2):
  - Stimulus: 5 taken branches.
  - Response: cnt_branch=cnt_taken=3 (saturated).
  - Stimulus: stat_clr coincident with a capture.
  - Response: counters 0 next cycle.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: request/response bundle between the decode stage and the branch resolver
interface branch_resolve_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [2:0]      funct3;
  logic            is_branch;
  logic            is_jal;
  logic            is_jalr;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic            out_mispredict;
  logic            out_illegal;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_redirect_pc;
  modport master (
    output in_valid, rs1, rs2, pc, imm, funct3, is_branch, is_jal, is_jalr,
           pred_taken, pred_target, flush, out_ready,
    input  in_ready, out_valid, out_taken, out_mispredict, out_illegal,
           out_target, out_redirect_pc
  );
  modport slave (
    input  in_valid, rs1, rs2, pc, imm, funct3, is_branch, is_jal, is_jalr,
           pred_taken, pred_target, flush, out_ready,
    output in_ready, out_valid, out_taken, out_mispredict, out_illegal,
           out_target, out_redirect_pc
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch/jump resolution with prediction check and saturating statistics
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave br,
  input  logic                 stat_clr_i,
  output logic [CNT_W-1:0]     cnt_branch_o,
  output logic [CNT_W-1:0]     cnt_taken_o,
  output logic [CNT_W-1:0]     cnt_mispred_o
);
  logic             out_valid_q, out_valid_d;
  logic             taken_q, mispred_q, illegal_q;
  logic [XLEN-1:0]  target_q, redirect_q;
  logic [CNT_W-1:0] cnt_br_q, cnt_tk_q, cnt_mp_q;
  logic [CNT_W-1:0] cnt_br_d, cnt_tk_d, cnt_mp_d;
  logic             is_jalr, is_jal, is_br, br_taken, taken, illegal, mispred, capture;
  logic [XLEN-1:0]  pc4, target, redirect;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return c + CNT_W'(inc && !(&c));
  endfunction

  assign br.in_ready = !out_valid_q || br.out_ready;
  assign capture     = br.in_valid && br.in_ready && !br.flush;

  // Decode op class by priority, evaluate the condition, target and prediction check
  always_comb begin
    is_jalr  = br.is_jalr;
    is_jal   = br.is_jal && !br.is_jalr;
    is_br    = br.is_branch && !br.is_jal && !br.is_jalr;
    pc4      = br.pc + XLEN'(4);
    br_taken = 1'b0;
    case (br.funct3)
      3'b000:  br_taken = br.rs1 == br.rs2;
      3'b001:  br_taken = br.rs1 != br.rs2;
      3'b100:  br_taken = $signed(br.rs1) < $signed(br.rs2);
      3'b101:  br_taken = $signed(br.rs1) >= $signed(br.rs2);
      3'b110:  br_taken = br.rs1 < br.rs2;
      3'b111:  br_taken = br.rs1 >= br.rs2;
      default: br_taken = 1'b0;
    endcase
    illegal  = is_br && br.funct3[2:1] == 2'b01;
    taken    = is_jalr || is_jal || (is_br && br_taken);
    target   = is_jalr ? ((br.rs1 + br.imm) & ~XLEN'(1)) :
               (is_jal || is_br) ? br.pc + br.imm : pc4;
    redirect = taken ? target : pc4;
    mispred  = (taken != br.pred_taken) || (taken && br.pred_target != target);
  end

  // Next valid state and counter updates; flush beats capture, clear beats increment
  always_comb begin
    out_valid_d = br.flush ? 1'b0 : capture ? 1'b1 : br.out_ready ? 1'b0 : out_valid_q;
    cnt_br_d    = stat_clr_i ? '0 : capture ? sat_inc(cnt_br_q, is_br) : cnt_br_q;
    cnt_tk_d    = stat_clr_i ? '0 : capture ? sat_inc(cnt_tk_q, is_br && taken) : cnt_tk_q;
    cnt_mp_d    = stat_clr_i ? '0 : capture ? sat_inc(cnt_mp_q, mispred) : cnt_mp_q;
  end

  // Result and statistics registers; result fields only move on capture so they hold under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      mispred_q   <= 1'b0;
      illegal_q   <= 1'b0;
      target_q    <= '0;
      redirect_q  <= '0;
      cnt_br_q    <= '0;
      cnt_tk_q    <= '0;
      cnt_mp_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      cnt_br_q    <= cnt_br_d;
      cnt_tk_q    <= cnt_tk_d;
      cnt_mp_q    <= cnt_mp_d;
      if (capture) begin
        taken_q    <= taken;
        mispred_q  <= mispred;
        illegal_q  <= illegal;
        target_q   <= target;
        redirect_q <= redirect;
      end
    end
  end

  assign br.out_valid       = out_valid_q;
  assign br.out_taken       = taken_q;
  assign br.out_mispredict  = mispred_q;
  assign br.out_illegal     = illegal_q;
  assign br.out_target      = target_q;
  assign br.out_redirect_pc = redirect_q;
  assign cnt_branch_o       = cnt_br_q;
  assign cnt_taken_o        = cnt_tk_q;
  assign cnt_mispred_o      = cnt_mp_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors with hand-computed expectations for branch_resolve_unit
module tb_branch_resolve_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stat_clr = 1'b0;
  logic [1:0] cnt_branch, cnt_taken, cnt_mispred;
  int         checks = 0;
  int         errors = 0;

  branch_resolve_unit_if #(.XLEN(32)) bus ();

  branch_resolve_unit #(.XLEN(32), .CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .br           (bus.slave),
    .stat_clr_i   (stat_clr),
    .cnt_branch_o (cnt_branch),
    .cnt_taken_o  (cnt_taken),
    .cnt_mispred_o(cnt_mispred)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // cls = {jalr, jal, branch}
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] i, input logic [2:0] f, input logic [2:0] cls,
                       input logic pt, input logic [31:0] ptg);
    bus.rs1 = a; bus.rs2 = b; bus.pc = p; bus.imm = i; bus.funct3 = f;
    bus.is_jalr = cls[2]; bus.is_jal = cls[1]; bus.is_branch = cls[0];
    bus.pred_taken = pt; bus.pred_target = ptg;
    bus.in_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                      input logic [31:0] i, input logic [2:0] f, input logic [2:0] cls,
                      input logic pt, input logic [31:0] ptg);
    drive(a, b, p, i, f, cls, pt, ptg);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_stats();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
  endtask

  logic [2:0] f3s [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
  logic       tks [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flush = 1'b0;
    bus.rs1 = '0; bus.rs2 = '0; bus.pc = '0; bus.imm = '0; bus.funct3 = '0;
    bus.is_branch = 1'b0; bus.is_jal = 1'b0; bus.is_jalr = 1'b0;
    bus.pred_taken = 1'b0; bus.pred_target = '0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_taken", bus.out_taken, 0);
    check("rst_mispred", bus.out_mispredict, 0);
    check("rst_illegal", bus.out_illegal, 0);
    check("rst_target", bus.out_target, 0);
    check("rst_redirect", bus.out_redirect_pc, 0);
    check("rst_cnt_branch", cnt_branch, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Branch type sweep
    for (int k = 0; k < 6; k++) begin
      send(32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, f3s[k], 3'b001, 1'b0, 32'h0);
      check($sformatf("sweep%0d_valid", k), bus.out_valid, 1);
      check($sformatf("sweep%0d_taken", k), bus.out_taken, tks[k]);
      check($sformatf("sweep%0d_target", k), bus.out_target, 32'h120);
      check($sformatf("sweep%0d_redirect", k), bus.out_redirect_pc, tks[k] ? 32'h120 : 32'h104);
      check($sformatf("sweep%0d_mispred", k), bus.out_mispredict, tks[k]);
    end
    step();
    check("sweep_drained", bus.out_valid, 0);
    check("sweep_cnt_branch_sat", cnt_branch, 3);
    check("sweep_cnt_taken", cnt_taken, 3);
    check("sweep_cnt_mispred_sat", cnt_mispred, 3);
    clear_stats();
    check("clr_cnt_branch", cnt_branch, 0);
    check("clr_cnt_taken", cnt_taken, 0);

    // Equality corner and illegal funct3
    send(32'h5, 32'h5, 32'h100, 32'h20, 3'b101, 3'b001, 1'b1, 32'h120);
    check("bge_eq_taken", bus.out_taken, 1);
    check("bge_eq_mispred", bus.out_mispredict, 0);
    send(32'h5, 32'h5, 32'h100, 32'h20, 3'b111, 3'b001, 1'b1, 32'h120);
    check("bgeu_eq_taken", bus.out_taken, 1);
    clear_stats();
    send(32'h5, 32'h5, 32'h100, 32'h20, 3'b010, 3'b001, 1'b0, 32'h0);
    check("ill_illegal", bus.out_illegal, 1);
    check("ill_taken", bus.out_taken, 0);
    check("ill_redirect", bus.out_redirect_pc, 32'h104);
    check("ill_cnt_branch", cnt_branch, 1);
    check("ill_cnt_taken", cnt_taken, 0);
    check("ill_cnt_mispred", cnt_mispred, 0);

    // JALR with wrap and bit 0 cleared, JAL, wrap of pc+4, non-control op
    send(32'hFFFF_FFF0, 32'h0, 32'h200, 32'h13, 3'b000, 3'b100, 1'b1, 32'h2);
    check("jalr_target", bus.out_target, 32'h2);
    check("jalr_taken", bus.out_taken, 1);
    check("jalr_redirect", bus.out_redirect_pc, 32'h2);
    check("jalr_mispred", bus.out_mispredict, 0);
    check("jalr_illegal", bus.out_illegal, 0);
    send(32'h0, 32'h0, 32'h1000, 32'h10, 3'b000, 3'b011, 1'b1, 32'h1014);
    check("jal_prio_target", bus.out_target, 32'h1010);
    check("jal_badtgt_mispred", bus.out_mispredict, 1);
    send(32'h1, 32'h2, 32'hFFFF_FFFC, 32'h8, 3'b000, 3'b001, 1'b0, 32'h0);
    check("wrap_taken", bus.out_taken, 0);
    check("wrap_redirect", bus.out_redirect_pc, 32'h0);
    check("wrap_mispred", bus.out_mispredict, 0);
    send(32'h0, 32'h0, 32'h40, 32'h8, 3'b000, 3'b000, 1'b1, 32'h48);
    check("nc_target", bus.out_target, 32'h44);
    check("nc_taken", bus.out_taken, 0);
    check("nc_mispred", bus.out_mispredict, 1);
    step();
    clear_stats();

    // Backpressure: A captured, B held for 3 stalled cycles, then released
    bus.out_ready = 1'b0;
    send(32'h7, 32'h7, 32'h300, 32'h8, 3'b000, 3'b001, 1'b0, 32'h0);
    drive(32'h7, 32'h7, 32'h400, 32'h8, 3'b001, 3'b001, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d_in_ready", k), bus.in_ready, 0);
      check($sformatf("bp%0d_valid", k), bus.out_valid, 1);
      check($sformatf("bp%0d_target", k), bus.out_target, 32'h308);
      check($sformatf("bp%0d_taken", k), bus.out_taken, 1);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("bp_b_target", bus.out_target, 32'h408);
    check("bp_b_redirect", bus.out_redirect_pc, 32'h404);
    check("bp_b_valid", bus.out_valid, 1);
    step();
    check("bp_no_dup", bus.out_valid, 0);
    check("bp_cnt_branch", cnt_branch, 2);
    check("bp_cnt_taken", cnt_taken, 1);
    check("bp_cnt_mispred", cnt_mispred, 1);
    clear_stats();

    // Flush with a held result and a new op offered
    bus.out_ready = 1'b0;
    send(32'h1, 32'h2, 32'h500, 32'h8, 3'b000, 3'b001, 1'b0, 32'h0);
    check("fl_pre_valid", bus.out_valid, 1);
    check("fl_pre_cnt_branch", cnt_branch, 1);
    drive(32'h3, 32'h3, 32'h600, 32'h8, 3'b000, 3'b001, 1'b0, 32'h0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_valid", bus.out_valid, 0);
    check("fl_cnt_branch", cnt_branch, 1);
    check("fl_cnt_taken", cnt_taken, 0);
    check("fl_cnt_mispred", cnt_mispred, 0);

    // Asynchronous reset mid-stall
    send(32'h0, 32'h0, 32'h700, 32'h40, 3'b000, 3'b010, 1'b0, 32'h0);
    check("ar_pre_valid", bus.out_valid, 1);
    check("ar_pre_cnt_mispred", cnt_mispred, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", bus.out_valid, 0);
    check("ar_taken", bus.out_taken, 0);
    check("ar_target", bus.out_target, 0);
    check("ar_redirect", bus.out_redirect_pc, 0);
    check("ar_cnt_branch", cnt_branch, 0);
    check("ar_cnt_mispred", cnt_mispred, 0);
    bus.out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    check("ar_idle_valid", bus.out_valid, 0);

    // Saturation with 5 taken branches, then clear coincident with capture
    for (int k = 0; k < 5; k++) send(32'h9, 32'h9, 32'h800, 32'h10, 3'b000, 3'b001, 1'b1, 32'h810);
    check("sat_cnt_branch", cnt_branch, 3);
    check("sat_cnt_taken", cnt_taken, 3);
    check("sat_cnt_mispred", cnt_mispred, 0);
    stat_clr = 1'b1;
    send(32'h9, 32'h9, 32'h800, 32'h10, 3'b000, 3'b001, 1'b0, 32'h0);
    stat_clr = 1'b0;
    check("clrcap_valid", bus.out_valid, 1);
    check("clrcap_mispred", bus.out_mispredict, 1);
    check("clrcap_cnt_branch", cnt_branch, 0);
    check("clrcap_cnt_taken", cnt_taken, 0);
    check("clrcap_cnt_mispred", cnt_mispred, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
